load_store_unit: RTL and testbench
==================================

# load_store_unit

Byte-addressed load/store front end that sits between the execute stage and `data_memory`. It converts byte, halfword and word requests into word accesses on the memory's 8-bit word-indexed, asynchronous-read / synchronous-write port. It performs sign/zero extension on loads and read-modify-write merging on sub-word stores, with a valid/ready request handshake and a one-cycle response pulse.

## Interface
Parameters:
- none; all widths are fixed by the 256 x 32 data memory.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the unit accepts a request; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  10  byte address; [9:2] is the word index, [1:0] is the byte offset.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse; the consumer cannot stall it.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request.
- mem_raddr  out  8  connects to `data_addr_in`.
- mem_rdata  in  32  connects to `data_out`; combinational read.
- mem_waddr  out  8  connects to `data_addr_wr`.
- mem_wdata  out  32  connects to `data_in`.
- mem_wr  out  1  connects to `m_wr`.

## Operation
- **Byte order:** little-endian; offset k selects bits [8k+7:8k].
- **Accept:** a request is captured on the rising edge where `req_valid && req_ready`. The captured fields are address, size, signed, wr and wdata.
- **States:**
  - IDLE:
    - A load goes to RD.
    - A word store goes to WR.
    - A sub-word store goes to RD.
    - A misaligned request goes to ERR.
  - RD:
    - `mem_raddr` = captured word index.
    - Load: extract the addressed lane, extend it, and register it into `resp_rdata`. Pulse `resp_valid` and go to IDLE.
    - Store: merge the store lane(s) into `mem_rdata`, hold the merged word in the write buffer, and go to WR.
  - WR:
    - `mem_wr` = 1, `mem_waddr` = word index, `mem_wdata` = buffer.
    - Pulse `resp_valid` and go to IDLE.
  - ERR:
    - No memory access.
    - Pulse `resp_valid` with `resp_err` = 1 and `resp_rdata` = 0.
    - Go to IDLE.
- **Misaligned:** half at an odd offset, word at a nonzero offset, or size 11.
- **Decoding:** `mem_wr` is decoded from the registered state only; no combinational path exists from `req_*` to `mem_wr`.
- **resp_err** is 0 on every successful response.
- **Hazards:** a load that follows a store is issued only after the store's WR edge, so no store-to-load hazard exists.

## Timing
- **Reset values:**
  - `resp_valid`, `resp_err`, `mem_wr` = 0.
  - `resp_rdata`, `mem_raddr`, `mem_waddr`, `mem_wdata` = 0.
  - State is IDLE, so `req_ready` = 1.
- **Latency and throughput** (request accepted at the edge ending cycle N):
  - Load: RD in N+1; `resp_valid` in N+2. One load every 2 cycles.
  - Word store: WR in N+1 (memory written at the end of N+1); `resp_valid` in N+2.
  - Sub-word store: RD in N+1, WR in N+2; `resp_valid` in N+3.
  - Error: `resp_valid` / `resp_err` in N+2.
- **Response timing:** `resp_valid` and `req_ready` are both high in the response cycle. A back-to-back request is accepted in that same cycle.
- **Inputs while busy:** changes to `req_*` while not in IDLE are ignored.
- **Reset mid-operation:** asserting `rst_n` low forces IDLE asynchronously.
  - `mem_wr` drops immediately.
  - A pending write is abandoned and memory is not modified.
  - No `resp_valid` is produced for the aborted request.

## Configuration
- **`LSU_ERR_EN` defined:** misaligned detection and the ERR state are compiled in, as described above.
- **`LSU_ERR_EN` undefined:**
  - Address bits below the access size are forced to 0: word → [1:0] = 0, half → [0] = 0.
  - Size 11 is treated as word.
  - `resp_err` is tied to 0 and there is no ERR state.

## Test plan
Preload word 0x10 = 0x8899AABB.
- **Reset:** hold `rst_n` low → all outputs at their reset values and `req_ready` = 1. Release and check no `mem_wr` pulse occurs.
- **Byte loads:** load byte at 0x041.
  - signed → `resp_rdata` = 0xFFFFFFAA in N+2.
  - unsigned → 0x000000AA.
  - Signed half at 0x042 → 0xFFFF8899.
- **Byte store:** store byte 0x5C at 0x043 → `mem_raddr` = 0x10 in N+1; `mem_wr` = 1 with `mem_wdata` = 0x5C99AABB in N+2; `resp_valid` in N+3. A following word load at 0x040 → 0x5C99AABB.
- **Word store:** store word 0x12345678 at 0x044 → `mem_wr` in N+1 with `mem_waddr` = 0x11; `resp_valid` in N+2. A back-to-back word load at 0x044, accepted in N+2 → 0x12345678.
- **Misaligned load:** word load at 0x042.
  - With `LSU_ERR_EN`: `resp_err` = 1, `resp_rdata` = 0 in N+2, and no `mem_wr`.
  - Without: returns word 0x10 and `resp_err` = 0.
- **Reset mid-store:** assert `rst_n` low during WR of a byte store → `mem_wr` falls immediately and word 0x10 is unchanged on readback.

Source files
------------

// File: rtl/lsu_if.sv
// Request/response and data-memory port bundle for load_store_unit.
// slave = the LSU side, master = the execute stage / memory side.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  mem_raddr;
   logic [31:0] mem_rdata;
   logic [7:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wr;

   modport slave (
      input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_raddr, mem_waddr, mem_wdata, mem_wr
   );

   modport master (
      output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_raddr, mem_waddr, mem_wdata, mem_wr
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a 256 x 32 async-read memory.
// Optional macro LSU_ERR_EN: misalignment detection and the ERR response state.
module load_store_unit (
   input  logic  clk,
   input  logic  rst_n,
   lsu_if.slave  bus
);

`ifdef LSU_ERR_EN
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ERR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

   state_t      state_q;
   logic [9:0]  addr_q;
   logic [1:0]  size_q;
   logic        sgn_q;
   logic        wr_q;
   logic [31:0] wbuf_q;
   logic        resp_valid_q;
   logic [31:0] rdata_q;
   logic [9:0]  addr_d;
   logic [1:0]  size_d;
`ifdef LSU_ERR_EN
   logic        resp_err_q;
   logic        misal_d;
`endif

   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (size)
         2'b00:   load_extract = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'b01:   load_extract = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: load_extract = w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] off, input logic [1:0] size);
      logic [31:0] m;
      m = old;
      case (size)
         2'b00: m[{off, 3'b000} +: 8] = wd[7:0];
         2'b01: if (off[1]) m[31:16] = wd[15:0];
                else        m[15:0]  = wd[15:0];
         default: m = wd;
      endcase
      store_merge = m;
   endfunction

   // Request normalisation: either flag misalignment or force the low address bits.
   always_comb begin
      size_d = bus.req_size;
      addr_d = bus.req_addr;
`ifdef LSU_ERR_EN
      misal_d = (bus.req_size == 2'b11) ||
                (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
      if (bus.req_size == 2'b11) size_d = 2'b10;
      if (size_d == 2'b10)       addr_d[1:0] = 2'b00;
      else if (size_d == 2'b01)  addr_d[0] = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         size_q       <= '0;
         sgn_q        <= 1'b0;
         wr_q         <= 1'b0;
         wbuf_q       <= '0;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
`ifdef LSU_ERR_EN
         resp_err_q   <= 1'b0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
`ifdef LSU_ERR_EN
         resp_err_q   <= 1'b0;
`endif
         case (state_q)
            S_IDLE: if (bus.req_valid) begin
               addr_q <= addr_d;
               size_q <= size_d;
               sgn_q  <= bus.req_signed;
               wr_q   <= bus.req_wr;
               wbuf_q <= bus.req_wdata;
`ifdef LSU_ERR_EN
               if (misal_d)                              state_q <= S_ERR;
               else
`endif
               if (bus.req_wr && size_d == 2'b10)        state_q <= S_WR;
               else                                      state_q <= S_RD;
            end
            S_RD: begin
               if (wr_q) begin
                  wbuf_q  <= store_merge(bus.mem_rdata, wbuf_q, addr_q[1:0], size_q);
                  state_q <= S_WR;
               end else begin
                  rdata_q      <= load_extract(bus.mem_rdata, addr_q[1:0], size_q, sgn_q);
                  resp_valid_q <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            S_WR: begin
               rdata_q      <= '0;
               resp_valid_q <= 1'b1;
               state_q      <= S_IDLE;
            end
`ifdef LSU_ERR_EN
            S_ERR: begin
               rdata_q      <= '0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b1;
               state_q      <= S_IDLE;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // mem_wr comes from the state register only, so an async reset kills it at once.
   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata_q;
`ifdef LSU_ERR_EN
   assign bus.resp_err   = resp_err_q;
`else
   assign bus.resp_err   = 1'b0;
`endif
   assign bus.mem_raddr  = addr_q[9:2];
   assign bus.mem_waddr  = addr_q[9:2];
   assign bus.mem_wdata  = wbuf_q;
   assign bus.mem_wr     = (state_q == S_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a 256 x 32 memory model.
module tb_load_store_unit;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_wdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic preload = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] mem [0:255];

   lsu_if bus ();

   load_store_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_raddr];
   always @(posedge clk) begin
      if (preload)         mem[8'h10] <= 32'h8899AABB;
      else if (bus.mem_wr) mem[bus.mem_waddr] <= bus.mem_wdata;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_wr, input logic [31:0] exp_wdata);
      vec_t v;
      v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.req_valid  = 1'b1;
      bus.req_wr     = v.wr;
      bus.req_size   = v.size;
      bus.req_signed = v.sgn;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
   endtask

   task automatic scramble();
      bus.req_valid  = 1'b0;
      bus.req_wr     = 1'b1;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b1;
      bus.req_addr   = 10'h3FF;
      bus.req_wdata  = 32'hA5A5A5A5;
   endtask

   task automatic run_req(input string tag, input vec_t v);
      int cyc;
      int nwr;
      logic got;
      @(negedge clk);
      chk({tag, "_ready_idle"}, {31'h0, bus.req_ready}, 32'h1);
      drive(v);
      @(posedge clk);
      #1 scramble();
      cyc = 0; nwr = 0; got = 1'b0;
      while (!got && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1 && !v.exp_err)
            chk({tag, "_raddr"}, {24'h0, bus.mem_raddr}, {24'h0, v.addr[9:2]});
         if (bus.mem_wr) begin
            nwr++;
            chk({tag, "_waddr"}, {24'h0, bus.mem_waddr}, {24'h0, v.addr[9:2]});
            chk({tag, "_wdata"}, bus.mem_wdata, v.exp_wdata);
         end
         if (bus.resp_valid) got = 1'b1;
      end
      chk({tag, "_lat"}, cyc, v.exp_lat);
      chk({tag, "_rdata"}, bus.resp_rdata, v.exp_rdata);
      chk({tag, "_err"}, {31'h0, bus.resp_err}, {31'h0, v.exp_err});
      chk({tag, "_ready_resp"}, {31'h0, bus.req_ready}, 32'h1);
      chk({tag, "_nwr"}, nwr, v.exp_wr);
   endtask

   vec_t vt [14];

   initial begin
      scramble();
      vt[0]  = mk(0, 2'b00, 1, 10'h041, 0, 32'hFFFFFFAA, 0, 2, 0, 0);
      vt[1]  = mk(0, 2'b00, 0, 10'h041, 0, 32'h000000AA, 0, 2, 0, 0);
      vt[2]  = mk(0, 2'b01, 1, 10'h042, 0, 32'hFFFF8899, 0, 2, 0, 0);
      vt[3]  = mk(0, 2'b01, 0, 10'h040, 0, 32'h0000AABB, 0, 2, 0, 0);
      vt[4]  = mk(0, 2'b00, 1, 10'h040, 0, 32'hFFFFFFBB, 0, 2, 0, 0);
      vt[5]  = mk(0, 2'b00, 1, 10'h043, 0, 32'hFFFFFF88, 0, 2, 0, 0);
      vt[6]  = mk(1, 2'b00, 0, 10'h043, 32'h0000005C, 0, 0, 3, 1, 32'h5C99AABB);
      vt[7]  = mk(0, 2'b10, 0, 10'h040, 0, 32'h5C99AABB, 0, 2, 0, 0);
      vt[8]  = mk(1, 2'b01, 0, 10'h040, 32'hFFFFBEEF, 0, 0, 3, 1, 32'h5C99BEEF);
      vt[9]  = mk(1, 2'b10, 0, 10'h044, 32'h12345678, 0, 0, 2, 1, 32'h12345678);
      vt[10] = mk(0, 2'b10, 0, 10'h040, 0, 32'h5C99BEEF, 0, 2, 0, 0);
`ifdef LSU_ERR_EN
      vt[11] = mk(0, 2'b10, 0, 10'h042, 0, 32'h0, 1, 2, 0, 0);
      vt[12] = mk(0, 2'b01, 0, 10'h045, 0, 32'h0, 1, 2, 0, 0);
      vt[13] = mk(0, 2'b11, 0, 10'h044, 0, 32'h0, 1, 2, 0, 0);
`else
      vt[11] = mk(0, 2'b10, 0, 10'h042, 0, 32'h5C99BEEF, 0, 2, 0, 0);
      vt[12] = mk(0, 2'b01, 0, 10'h045, 0, 32'h00005678, 0, 2, 0, 0);
      vt[13] = mk(0, 2'b11, 0, 10'h044, 0, 32'h12345678, 0, 2, 0, 0);
`endif

      // Reset held low: every output at its reset value.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_err",   {31'h0, bus.resp_err},   32'h0);
      chk("rst_mem_wr",     {31'h0, bus.mem_wr},     32'h0);
      chk("rst_rdata",      bus.resp_rdata,          32'h0);
      chk("rst_raddr",      {24'h0, bus.mem_raddr},  32'h0);
      chk("rst_waddr",      {24'h0, bus.mem_waddr},  32'h0);
      chk("rst_wdata",      bus.mem_wdata,           32'h0);
      chk("rst_ready",      {31'h0, bus.req_ready},  32'h1);
      preload = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_mem_wr%0d", i), {31'h0, bus.mem_wr}, 32'h0);
      end

      for (int i = 0; i < 14; i++) run_req($sformatf("v%0d", i), vt[i]);

      // Back-to-back: word store, then a load accepted in the store's response cycle.
      @(negedge clk);
      drive(mk(1, 2'b10, 0, 10'h048, 32'hCAFEF00D, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 drive(mk(0, 2'b10, 0, 10'h048, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("b2b_mem_wr",   {31'h0, bus.mem_wr},    32'h1);
      chk("b2b_waddr",    {24'h0, bus.mem_waddr}, 32'h12);
      chk("b2b_busy",     {31'h0, bus.req_ready}, 32'h0);
      @(negedge clk);
      chk("b2b_st_resp",  {31'h0, bus.resp_valid}, 32'h1);
      chk("b2b_st_ready", {31'h0, bus.req_ready},  32'h1);
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      chk("b2b_ld_raddr", {24'h0, bus.mem_raddr}, 32'h12);
      chk("b2b_ld_noresp", {31'h0, bus.resp_valid}, 32'h0);
      @(negedge clk);
      chk("b2b_ld_resp",  {31'h0, bus.resp_valid}, 32'h1);
      chk("b2b_ld_rdata", bus.resp_rdata, 32'hCAFEF00D);

      // Reset asserted during the WR cycle of a byte store.
      @(negedge clk);
      drive(mk(1, 2'b00, 0, 10'h040, 32'h00000077, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      chk("mid_raddr", {24'h0, bus.mem_raddr}, 32'h10);
      chk("mid_rd_nowr", {31'h0, bus.mem_wr}, 32'h0);
      @(negedge clk);
      chk("mid_wr",    {31'h0, bus.mem_wr}, 32'h1);
      chk("mid_wdata", bus.mem_wdata, 32'h5C99BE77);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_wr_drop", {31'h0, bus.mem_wr},    32'h0);
      chk("mid_ready",   {31'h0, bus.req_ready}, 32'h1);
      @(negedge clk);
      chk("mid_noresp0", {31'h0, bus.resp_valid}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_noresp1", {31'h0, bus.resp_valid}, 32'h0);
      run_req("mid_readback", mk(0, 2'b10, 0, 10'h040, 0, 32'h5C99BEEF, 0, 2, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
